text_write_scheduler: RTL
=========================

# text_write_scheduler

Sequences all CPU writes into the character RAM's CPU port so text updates never corrupt a glyph mid-draw. CPU write requests are buffered in a small FIFO and committed one per cycle only while the display is in vertical blanking. A built-in clear engine fills every cell with one value on command. The block sits between the CPU bus and the character RAM CPU write port, in the `cpu_clk` domain. CPU reads bypass this block.

## Interface
Parameters:
- `TEXTADDR_WIDTH`, 14: character cell address width.
- `N_CELLS`, 16080: number of cells (`N_COL*N_ROW`); clear covers 0..N_CELLS-1.
- `FIFO_DEPTH`, 16: pending-write entries; power of two.
- `LEVEL_WIDTH`, 5: `$clog2(FIFO_DEPTH)+1`.

Ports:
- `cpu_clk`  in  1  sole clock.
- `rst_n`  in  1  synchronous, active-low reset.
- `vBlank`  in  1  vertical blanking from the pixel domain; asynchronous to `cpu_clk`.
- `req_valid`  in  1  CPU write request.
- `req_ready`  out  1  request accepted on `req_valid & req_ready` at a rising edge.
- `req_addr`  in  TEXTADDR_WIDTH  cell address.
- `req_data`  in  16  `{attribute[7:0], char[7:0]}`.
- `clr_start`  in  1  single-cycle pulse that requests a full-screen fill.
- `clr_data`  in  16  fill value; sampled on the accepted `clr_start`.
- `busy`  out  1  FIFO non-empty, clear pending, or clear active.
- `fifo_level`  out  LEVEL_WIDTH  current FIFO occupancy.
- `ram_we`  out  1  character RAM write strobe.
- `ram_addr`  out  TEXTADDR_WIDTH  character RAM write address.
- `ram_data`  out  16  character RAM write data.

## Operation
- `vBlank` passes through a 2-flop synchronizer to produce `vb_s`. The commit window `win` is `vb_s` when the macro is compiled in, otherwise constant 1.
- FSM states:
  - IDLE: when `win` is high and the FIFO is non-empty, go to DRAIN. When `win` is high, the FIFO is empty and a clear is pending, go to CLEAR.
  - DRAIN: pop one entry per cycle while `win` is high and the FIFO is non-empty. Return to IDLE when the FIFO empties or `win` drops.
  - CLEAR: write `clr_data` to `clr_addr`, then increment `clr_addr`, one cell per cycle while `win` is high. When `win` is low, hold `clr_addr` and stay in CLEAR. After writing cell `N_CELLS-1`, clear the pending flag and go to IDLE.
- `req_ready` is 1 when `fifo_level < FIFO_DEPTH` and no clear is pending or active.
- Ordering: every write accepted before `clr_start` commits before the first clear write. Requests arriving during a clear stall on `req_ready` = 0.
- `clr_start` is ignored while a clear is pending or active.
- `clr_start` and an accepted request in the same cycle: the request enters the FIFO first, then the clear is set pending.
- Accept and pop in the same cycle: `fifo_level` is unchanged.
- FIFO pointers wrap modulo `FIFO_DEPTH`.
- `clr_addr` counts 0..N_CELLS-1 with no wrap.
- When `rst_n` is low, including mid-drain or mid-clear: abort the operation, flush the FIFO, drop any pending clear, go to IDLE.

## Timing
- Reset values: `req_ready`=0, `busy`=0, `fifo_level`=0, `ram_we`=0, `ram_addr`=0, `ram_data`=0.
- `req_ready` rises in the first cycle after `rst_n` goes high.
- All outputs are registered.
- Ungated latency: a request accepted at edge N into an empty FIFO drives `ram_we`=1 in the cycle following edge N+2.
- Gated latency: `vBlank` rise to first `ram_we` is at most 4 edges (2 synchronizer + FSM + output register).
- `ram_we` stops at most 4 edges after `vBlank` falls.
- Throughput: one write per cycle in DRAIN and CLEAR.
- A full clear takes `N_CELLS` cycles of open window. At 100 MHz this fits inside one 1080p blanking interval (about 667 µs).
- `busy` falls in the cycle after the last `ram_we`.

## Configuration
- `TEXT_WRITE_VBLANK_GATE_EN` defined: commits and clear writes occur only while `vb_s`=1, so there are no visible artifacts.
- `TEXT_WRITE_VBLANK_GATE_EN` not defined: the synchronizer is removed and `win`=1. Writes commit immediately and transient single-frame corruption is accepted.

## Test plan
- Gated, `vBlank`=0: accept 16 writes (addr 0..15, data 0x0741+i); 17th request sees `req_ready`=0 and `fifo_level`=16. Raise `vBlank`: 16 consecutive `ram_we` pulses with matching addr/data in order, then `fifo_level`=0 and `busy`=0.
- Gated: drop `vBlank` after 5 pops. Required: `ram_we` stops within 4 edges and `fifo_level`=11; the remainder drains in order on the next `vBlank`.
- `clr_start` with `clr_data`=0x0720 while 3 writes are queued: the 3 writes commit first, then 16080 writes of 0x0720 to addresses 0..16079. `req_ready`=0 throughout; `busy` falls after address 16079.
- Ungated build: write addr 0x123, data 0x1F41, `vBlank`=0. Required: `ram_we` in the cycle after edge N+2.
- Assert `rst_n`=0 mid-clear at `clr_addr`=500. Required: all outputs return to reset values on that edge, and no further `ram_we` occurs.

Source files
------------

// File: rtl/text_write_scheduler.sv
// Buffers CPU character-RAM writes in a FIFO and commits them, or a full-screen clear, one per cycle
// inside the commit window. Define TEXT_WRITE_VBLANK_GATE_EN to open that window only during vBlank.
module text_write_scheduler #(
  parameter int TEXTADDR_WIDTH = 14,
  parameter int N_CELLS        = 16080,
  parameter int FIFO_DEPTH     = 16,
  parameter int LEVEL_WIDTH    = 5
) (
  input  logic                      cpu_clk,
  input  logic                      rst_n,
  input  logic                      vBlank,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic [TEXTADDR_WIDTH-1:0] req_addr,
  input  logic [15:0]               req_data,
  input  logic                      clr_start,
  input  logic [15:0]               clr_data,
  output logic                      busy,
  output logic [LEVEL_WIDTH-1:0]    fifo_level,
  output logic                      ram_we,
  output logic [TEXTADDR_WIDTH-1:0] ram_addr,
  output logic [15:0]               ram_data
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [TEXTADDR_WIDTH-1:0] LAST_CELL = TEXTADDR_WIDTH'(N_CELLS - 1);
  localparam logic [LEVEL_WIDTH-1:0]    FULL_LEVEL = LEVEL_WIDTH'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, DRAIN, CLEAR} state_t;

  state_t                    state_q, state_d;
  logic [PTR_W-1:0]          wrPtr_q, wrPtr_d, rdPtr_q, rdPtr_d;
  logic [LEVEL_WIDTH-1:0]    level_q, level_d;
  logic                      clrPend_q, clrPend_d;
  logic [TEXTADDR_WIDTH-1:0] clrAddr_q, clrAddr_d;
  logic [15:0]               clrData_q, clrData_d;
  logic                      ramWe_q, ramWe_d;
  logic [TEXTADDR_WIDTH-1:0] ramAddr_q, ramAddr_d;
  logic [15:0]               ramData_q, ramData_d;
  logic                      reqReady_q, reqReady_d;
  logic                      busy_q, busy_d;
  logic [TEXTADDR_WIDTH+15:0] mem_q [FIFO_DEPTH];
  logic [TEXTADDR_WIDTH+15:0] head;
  logic                      push, pop, win;

`ifdef TEXT_WRITE_VBLANK_GATE_EN
  logic vbMeta_q, vbSync_q;

  always_ff @(posedge cpu_clk) begin
    if (!rst_n) begin
      vbMeta_q <= 1'b0;
      vbSync_q <= 1'b0;
    end else begin
      vbMeta_q <= vBlank;
      vbSync_q <= vbMeta_q;
    end
  end

  assign win = vbSync_q;
`else
  logic unusedVblank;
  assign unusedVblank = vBlank;
  assign win = 1'b1;
`endif

  assign push = req_valid & reqReady_q;
  assign head = mem_q[rdPtr_q];

  always_ff @(posedge cpu_clk) begin
    if (push) begin
      mem_q[wrPtr_q] <= {req_addr, req_data};
    end
  end

  always_comb begin
    state_d   = state_q;
    wrPtr_d   = wrPtr_q;
    rdPtr_d   = rdPtr_q;
    clrPend_d = clrPend_q;
    clrAddr_d = clrAddr_q;
    clrData_d = clrData_q;
    ramWe_d   = 1'b0;
    ramAddr_d = ramAddr_q;
    ramData_d = ramData_q;
    pop       = 1'b0;

    case (state_q)
      IDLE: begin
        if (win && level_q != '0) begin
          state_d = DRAIN;
        end else if (win && clrPend_q) begin
          state_d = CLEAR;
        end
      end
      DRAIN: begin
        if (win && level_q != '0) begin
          pop       = 1'b1;
          ramWe_d   = 1'b1;
          ramAddr_d = head[TEXTADDR_WIDTH+15:16];
          ramData_d = head[15:0];
        end
      end
      CLEAR: begin
        if (win) begin
          ramWe_d   = 1'b1;
          ramAddr_d = clrAddr_q;
          ramData_d = clrData_q;
          if (clrAddr_q == LAST_CELL) begin
            clrAddr_d = '0;
            clrPend_d = 1'b0;
            state_d   = IDLE;
          end else begin
            clrAddr_d = clrAddr_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (push) begin
      wrPtr_d = wrPtr_q + 1'b1;
    end
    if (pop) begin
      rdPtr_d = rdPtr_q + 1'b1;
    end
    level_d = level_q + LEVEL_WIDTH'(push) - LEVEL_WIDTH'(pop);

    if (state_q == DRAIN && (!win || level_d == '0)) begin
      state_d = IDLE;
    end

    // The pending flag stays set through CLEAR, so it blocks both new requests and a second clr_start.
    if (clr_start && !clrPend_q) begin
      clrPend_d = 1'b1;
      clrData_d = clr_data;
      clrAddr_d = '0;
    end

    reqReady_d = (level_d < FULL_LEVEL) && !clrPend_d;
    busy_d     = (level_d != '0) || clrPend_d || ramWe_d;
  end

  always_ff @(posedge cpu_clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      wrPtr_q    <= '0;
      rdPtr_q    <= '0;
      level_q    <= '0;
      clrPend_q  <= 1'b0;
      clrAddr_q  <= '0;
      clrData_q  <= '0;
      ramWe_q    <= 1'b0;
      ramAddr_q  <= '0;
      ramData_q  <= '0;
      reqReady_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      wrPtr_q    <= wrPtr_d;
      rdPtr_q    <= rdPtr_d;
      level_q    <= level_d;
      clrPend_q  <= clrPend_d;
      clrAddr_q  <= clrAddr_d;
      clrData_q  <= clrData_d;
      ramWe_q    <= ramWe_d;
      ramAddr_q  <= ramAddr_d;
      ramData_q  <= ramData_d;
      reqReady_q <= reqReady_d;
      busy_q     <= busy_d;
    end
  end

  assign req_ready  = reqReady_q;
  assign busy       = busy_q;
  assign fifo_level = level_q;
  assign ram_we     = ramWe_q;
  assign ram_addr   = ramAddr_q;
  assign ram_data   = ramData_q;

endmodule
